// File: rtl/avalon_pkg.sv
// Shared types for the CPU-side Avalon-MM memory initiator.
package avalon_pkg;

    localparam int LANES = 4;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10
    } mem_size_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUS  = 2'b01,
        ERR  = 2'b10
    } master_state_t;

endpackage

// File: rtl/avalon_lane_align.sv
// Combinational little-endian lane steering: store-side byteenable/writedata/misalign
// from the incoming request, load-side extraction/extension from the captured request.
module avalon_lane_align
    import avalon_pkg::*;
(
    input  logic [1:0]       st_size,
    input  logic [1:0]       st_offset,
    input  logic [31:0]      st_wdata,
    output logic [LANES-1:0] st_byteenable,
    output logic [31:0]      st_writedata,
    output logic             st_misalign,
    input  logic [1:0]       ld_size,
    input  logic [1:0]       ld_offset,
    input  logic             ld_signed,
    input  logic [31:0]      ld_readdata,
    output logic [31:0]      ld_rdata
);

    logic [31:0] ld_shifted;

    assign ld_shifted = ld_readdata >> {ld_offset, 3'b000};

    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        st_byteenable = '0;
        st_writedata  = st_wdata;
        st_misalign   = 1'b0;
        case (st_size)
            SIZE_BYTE: begin
                st_byteenable = 4'b0001 << st_offset;
                st_writedata  = {4{st_wdata[7:0]}};
            end
            SIZE_HALF: begin
                st_byteenable = st_offset[1] ? 4'b1100 : 4'b0011;
                st_writedata  = {2{st_wdata[15:0]}};
                st_misalign   = st_offset[0];
            end
            SIZE_WORD: begin
                st_byteenable = 4'b1111;
                st_misalign   = |st_offset;
            end
            default: st_misalign = 1'b1;
        endcase
    end

    always_comb begin
        ld_rdata = ld_readdata;
        case (ld_size)
            SIZE_BYTE: ld_rdata = {{24{ld_signed & ld_shifted[7]}}, ld_shifted[7:0]};
            SIZE_HALF: ld_rdata = {{16{ld_signed & ld_shifted[15]}}, ld_shifted[15:0]};
            default:   ld_rdata = ld_readdata;
        endcase
    end

endmodule

// File: rtl/avalon_mem_master.sv
// Avalon-MM initiator: one CPU load/store at a time, fully serialised, honours waitrequest,
// returns extended load data with a one-cycle response pulse.
module avalon_mem_master
    import avalon_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [DATA_W-1:0] resp_rdata,
    output logic [ADDR_W-1:0] address,
    output logic [LANES-1:0]  byteenable,
    output logic              read,
    output logic              write,
    output logic [DATA_W-1:0] writedata,
    input  logic              waitrequest,
    input  logic [DATA_W-1:0] readdata
);

    master_state_t     state_q, state_d;
    logic [ADDR_W-1:0] address_q, address_d;
    logic [LANES-1:0]  byteenable_q, byteenable_d;
    logic [DATA_W-1:0] writedata_q, writedata_d;
    logic              read_q, read_d;
    logic              write_q, write_d;
    logic [1:0]        size_q, size_d;
    logic [1:0]        offset_q, offset_d;
    logic              signed_q, signed_d;
    logic              resp_valid_q, resp_valid_d;
    logic              resp_err_q, resp_err_d;
    logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;

    logic [LANES-1:0]  st_byteenable;
    logic [DATA_W-1:0] st_writedata;
    logic              st_misalign;
    logic [DATA_W-1:0] ld_rdata;

    avalon_lane_align u_align (
        .st_size      (req_size),
        .st_offset    (req_addr[1:0]),
        .st_wdata     (req_wdata),
        .st_byteenable(st_byteenable),
        .st_writedata (st_writedata),
        .st_misalign  (st_misalign),
        .ld_size      (size_q),
        .ld_offset    (offset_q),
        .ld_signed    (signed_q),
        .ld_readdata  (readdata),
        .ld_rdata     (ld_rdata)
    );

    always_comb begin
        state_d      = state_q;
        address_d    = address_q;
        byteenable_d = byteenable_q;
        writedata_d  = writedata_q;
        read_d       = read_q;
        write_d      = write_q;
        size_d       = size_q;
        offset_d     = offset_q;
        signed_d     = signed_q;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = resp_rdata_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (st_misalign) begin
                        state_d = ERR;
                    end else begin
                        state_d      = BUS;
                        address_d    = {2'b00, req_addr[ADDR_W-1:2]};
                        byteenable_d = st_byteenable;
                        writedata_d  = st_writedata;
                        read_d       = ~req_write;
                        write_d      = req_write;
                        size_d       = req_size;
                        offset_d     = req_addr[1:0];
                        signed_d     = req_signed;
                    end
                end
            end
            BUS: begin
                if (!waitrequest) begin
                    state_d      = IDLE;
                    read_d       = 1'b0;
                    write_d      = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = write_q ? '0 : ld_rdata;
                end
            end
            ERR: begin
                state_d      = IDLE;
                resp_valid_d = 1'b1;
                resp_err_d   = 1'b1;
                resp_rdata_d = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            address_q    <= '0;
            byteenable_q <= '0;
            writedata_q  <= '0;
            read_q       <= 1'b0;
            write_q      <= 1'b0;
            size_q       <= 2'b00;
            offset_q     <= 2'b00;
            signed_q     <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            address_q    <= address_d;
            byteenable_q <= byteenable_d;
            writedata_q  <= writedata_d;
            read_q       <= read_d;
            write_q      <= write_d;
            size_q       <= size_d;
            offset_q     <= offset_d;
            signed_q     <= signed_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;
    assign address    = address_q;
    assign byteenable = byteenable_q;
    assign read       = read_q;
    assign write      = write_q;
    assign writedata  = writedata_q;

endmodule

// File: tb/tb_avalon_mem_master.sv
// Directed self-checking bench for avalon_mem_master with hand-computed expectations.
module tb_avalon_mem_master;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] address;
    logic [3:0]  byteenable;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic        waitrequest;
    logic [31:0] readdata;

    int n_checks = 0;
    int n_errors = 0;

    avalon_mem_master #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_err   (resp_err),
        .resp_rdata (resp_rdata),
        .address    (address),
        .byteenable (byteenable),
        .read       (read),
        .write      (write),
        .writedata  (writedata),
        .waitrequest(waitrequest),
        .readdata   (readdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issues one request, drives waitrequest high for nwait strobe cycles, checks bus and response.
    task automatic run_req(input string tag, input logic wr, input logic [1:0] size,
                           input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rdata, input int nwait, input logic exp_err,
                           input logic [31:0] exp_rdata, input logic [31:0] exp_addr,
                           input logic [3:0] exp_be, input logic [31:0] wd_mask,
                           input logic [31:0] exp_wd);
        int   strobes;
        int   lat;
        logic got;
        strobes = 0;
        lat     = 0;
        got     = 1'b0;
        @(negedge clk);
        check({tag, ":ready"}, {31'd0, req_ready}, 32'd1);
        req_write   = wr;
        req_size    = size;
        req_signed  = sgn;
        req_addr    = addr;
        req_wdata   = wdata;
        req_valid   = 1'b1;
        waitrequest = 1'b0;
        readdata    = rdata;
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        req_addr   = $urandom;
        req_wdata  = $urandom;
        req_size   = 2'($urandom_range(0, 3));
        req_write  = ~wr;
        req_signed = ~sgn;
        for (int i = 1; i <= 50 && !got; i++) begin
            @(negedge clk);
            if (read && write) check({tag, ":overlap"}, 32'd1, 32'd0);
            if (read || write) begin
                strobes++;
                check({tag, ":addr"}, address, exp_addr);
                check({tag, ":be"}, {28'd0, byteenable}, {28'd0, exp_be});
                check({tag, ":wd"}, writedata & wd_mask, exp_wd);
                check({tag, ":strobe"}, {30'd0, read, write}, {30'd0, ~wr, wr});
            end
            waitrequest = (strobes > 0) && (strobes <= nwait);
            if (resp_valid) begin
                got = 1'b1;
                lat = i;
            end
        end
        waitrequest = 1'b0;
        if (!got) begin
            check({tag, ":timeout"}, 32'd0, 32'd1);
        end else begin
            check({tag, ":lat"}, lat, exp_err ? 32'd2 : 32'(nwait + 2));
            check({tag, ":nstrobe"}, strobes, exp_err ? 32'd0 : 32'(nwait + 1));
            check({tag, ":err"}, {31'd0, resp_err}, {31'd0, exp_err});
            check({tag, ":rdata"}, resp_rdata, exp_rdata);
            check({tag, ":ready_at_resp"}, {31'd0, req_ready}, 32'd1);
        end
        @(negedge clk);
        check({tag, ":pulse"}, {31'd0, resp_valid}, 32'd0);
    endtask

    initial begin
        int overlap;
        int rd_cycles;
        int wr_cycles;
        int lat;
        logic got;

        rst_n       = 1'b0;
        req_valid   = 1'b0;
        req_write   = 1'b0;
        req_size    = 2'b00;
        req_signed  = 1'b0;
        req_addr    = '0;
        req_wdata   = '0;
        waitrequest = 1'b0;
        readdata    = '0;

        #3;
        check("rst:ready", {31'd0, req_ready}, 32'd1);
        check("rst:resp", {30'd0, resp_valid, resp_err}, 32'd0);
        check("rst:rdata", resp_rdata, 32'd0);
        check("rst:strobes", {30'd0, read, write}, 32'd0);
        check("rst:addr", address, 32'd0);
        check("rst:be", {28'd0, byteenable}, 32'd0);
        check("rst:wd", writedata, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        //       tag        wr    size   sgn   addr          wdata         rdata         nw err  exp_rdata     exp_addr      be       mask          exp_wd
        run_req("wload",    1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0,        32'hDEAD_BEEF, 0, 1'b0, 32'hDEAD_BEEF, 32'h0000_0004, 4'b1111, 32'h0,        32'h0);
        run_req("sbload",   1'b0, 2'b00, 1'b1, 32'h0000_0003, 32'h0,        32'h80FF_0000, 3, 1'b0, 32'hFFFF_FF80, 32'h0000_0000, 4'b1000, 32'h0,        32'h0);
        run_req("ubload",   1'b0, 2'b00, 1'b0, 32'h0000_0003, 32'h0,        32'h80FF_0000, 3, 1'b0, 32'h0000_0080, 32'h0000_0000, 4'b1000, 32'h0,        32'h0);
        run_req("hstore",   1'b1, 2'b01, 1'b0, 32'h0000_0006, 32'h0000_1234, 32'hFFFF_FFFF, 0, 1'b0, 32'h0,        32'h0000_0001, 4'b1100, 32'hFFFF_0000, 32'h1234_0000);
        run_req("bstore",   1'b1, 2'b00, 1'b0, 32'h0000_0101, 32'h0000_00A5, 32'h0,        1, 1'b0, 32'h0,        32'h0000_0040, 4'b0010, 32'h0000_FF00, 32'h0000_A500);
        run_req("shload",   1'b0, 2'b01, 1'b1, 32'h0000_0022, 32'h0,        32'h8001_1234, 0, 1'b0, 32'hFFFF_8001, 32'h0000_0008, 4'b1100, 32'h0,        32'h0);
        run_req("werr",     1'b0, 2'b10, 1'b0, 32'h0000_0002, 32'h0,        32'h1111_1111, 0, 1'b1, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h0);
        run_req("size3err", 1'b0, 2'b11, 1'b0, 32'h0000_0000, 32'h0,        32'h1111_1111, 0, 1'b1, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h0);
        run_req("herr",     1'b1, 2'b01, 1'b0, 32'h0000_0001, 32'h0000_5555, 32'h0,        0, 1'b1, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h0);

        // Back-to-back store then load with req_valid held high.
        overlap   = 0;
        rd_cycles = 0;
        wr_cycles = 0;
        @(negedge clk);
        req_write  = 1'b1;
        req_size   = 2'b10;
        req_signed = 1'b0;
        req_addr   = 32'h0000_0020;
        req_wdata  = 32'hCAFE_F00D;
        req_valid  = 1'b1;
        @(posedge clk);
        #1;
        req_write = 1'b0;
        req_addr  = 32'h0000_0024;
        readdata  = 32'h1122_3344;
        got = 1'b0;
        lat = 0;
        for (int i = 1; i <= 20 && !got; i++) begin
            @(negedge clk);
            if (read && write) overlap++;
            if (read) rd_cycles++;
            if (write) wr_cycles++;
            if (resp_valid) begin
                got = 1'b1;
                lat = i;
            end
        end
        check("b2b:first_lat", lat, 32'd2);
        check("b2b:first_ready", {31'd0, req_ready}, 32'd1);
        check("b2b:first_rdata", resp_rdata, 32'd0);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        got = 1'b0;
        lat = 0;
        for (int i = 1; i <= 20 && !got; i++) begin
            @(negedge clk);
            if (read && write) overlap++;
            if (read) rd_cycles++;
            if (write) wr_cycles++;
            if (resp_valid) begin
                got = 1'b1;
                lat = i;
            end
        end
        check("b2b:second_lat", lat, 32'd2);
        check("b2b:second_rdata", resp_rdata, 32'h1122_3344);
        check("b2b:overlap", overlap, 32'd0);
        check("b2b:rd_cycles", rd_cycles, 32'd1);
        check("b2b:wr_cycles", wr_cycles, 32'd1);

        // Reset asserted mid-BUS with waitrequest high.
        @(negedge clk);
        req_write   = 1'b0;
        req_size    = 2'b10;
        req_addr    = 32'h0000_0040;
        req_valid   = 1'b1;
        waitrequest = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("rstbus:read_c1", {31'd0, read}, 32'd1);
        @(negedge clk);
        check("rstbus:read_c2", {31'd0, read}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rstbus:read_drop", {31'd0, read}, 32'd0);
        check("rstbus:addr", address, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rstbus:no_resp", {31'd0, resp_valid}, 32'd0);
        end
        waitrequest = 1'b0;
        rst_n = 1'b1;
        check("rstbus:ready", {31'd0, req_ready}, 32'd1);
        run_req("post_rst", 1'b0, 2'b10, 1'b0, 32'h0000_0080, 32'h0, 32'h0BAD_CAFE, 1, 1'b0, 32'h0BAD_CAFE, 32'h0000_0020, 4'b1111, 32'h0, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/avalon_mem_master.md
# avalon_mem_master

Avalon-MM initiator for the CPU's memory path. Takes one CPU load/store at a time, performs byte-lane alignment, and drives the word-addressed Avalon-MM bus that the team's RAM slave responds on. It returns sign- or zero-extended load data with a single-cycle response pulse. Every Avalon transaction is fully serialised, and `waitrequest` is honoured for any number of cycles.

## Interface
Parameters:
- ADDR_W, 32, width of the CPU byte address and the Avalon address.
- DATA_W, 32, data width; fixed at 32 (4 byte lanes).

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  CPU request present
- req_ready  out  1  block can accept a request this cycle
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 halfword, 10 word; 11 illegal
- req_signed  in  1  load sign-extends when 1
- req_addr  in  32  CPU byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  one-cycle pulse: request completed
- resp_err  out  1  qualifies resp_valid: misaligned or illegal size
- resp_rdata  out  32  extended load data; 0 for stores and errors
- address  out  32  Avalon word address = req_addr >> 2
- byteenable  out  4  active lanes
- read  out  1  Avalon read strobe
- write  out  1  Avalon write strobe
- writedata  out  32  lane-shifted store data
- waitrequest  in  1  slave stall
- readdata  in  32  slave data, valid in the cycle `waitrequest` is low with `read` high

## Operation
- FSM states: IDLE, BUS, ERR.
- IDLE
  - req_ready = 1.
  - A request is accepted on req_valid && req_ready.
  - Misaligned or illegal request → ERR. Misaligned means: halfword with addr[0] = 1; word with addr[1:0] ≠ 0; or size 11.
  - Any other request → BUS. Address, byteenable, writedata and read/write are registered in the same edge.
- BUS
  - read or write held high with all bus outputs stable.
  - Stays in BUS while waitrequest = 1.
  - On the edge where waitrequest = 0 → IDLE, with resp_valid = 1 and resp_rdata registered.
- ERR: one cycle, issues no bus strobe. Next edge → IDLE with resp_valid = 1, resp_err = 1, resp_rdata = 0.
- Lane mapping is little-endian. Lane n uses bits [8n+7:8n].
  - Byte: byteenable = 1 << addr[1:0].
  - Half: byteenable = 0011 when addr[1] = 0, otherwise 1100.
  - Word: byteenable = 1111.
  - writedata = req_wdata << (8 × addr[1:0]); unused lanes carry replicated data.
- Load extraction: shift readdata right by 8 × addr[1:0], then take 8 or 16 bits. Sign-extend when req_signed, otherwise zero-extend. Word loads pass through unchanged.
- read and write are never high together. Neither is high outside BUS.
- Request inputs are sampled only at acceptance; later changes are ignored.

## Timing
- Reset values (async assert, deassert synchronised by the top level):
  - State: IDLE, req_ready = 1.
  - resp_valid = 0, resp_err = 0, resp_rdata = 0.
  - read = 0, write = 0, address = 0, byteenable = 0, writedata = 0.
- Latency, zero wait states:
  - Accept at edge 0.
  - Strobe high during cycle 1; completes at edge 1.
  - resp_valid high during cycle 2.
  - Each waitrequest cycle adds exactly 1.
- Error latency: resp_valid one cycle after acceptance.
- req_ready is high in the same cycle resp_valid is high. Back-to-back requests therefore cost 2 cycles each at zero wait.
- Reset mid-BUS: strobes drop immediately (asynchronous) and no response is issued.
- waitrequest is ignored outside BUS.

## Structure
- Package `avalon_pkg`:
  - mem_size_t enum (SIZE_BYTE, SIZE_HALF, SIZE_WORD).
  - master_state_t enum (IDLE, BUS, ERR).
  - Lane-count constant = 4.
- Sub-module `avalon_lane_align`, purely combinational:
  - Computes byteenable, shifted writedata and the misalign flag from size and addr[1:0].
  - Performs load extraction and extension.
- Top-level: FSM plus the output registers.

## Test plan
- Word load at 0x0000_0010, readdata 0xDEADBEEF, waitrequest low → address 0x4, byteenable 1111, read high 1 cycle; resp_valid in cycle 2 with rdata 0xDEADBEEF.
- Signed byte load at 0x0000_0003, readdata 0x80FF_0000, waitrequest high 3 cycles → read held 4 cycles with address stable; rdata 0xFFFF_FF80. Unsigned variant gives 0x0000_0080.
- Halfword store of 0x0000_1234 at 0x0000_0006 → byteenable 1100, writedata[31:16] = 0x1234, write high exactly 1 cycle at zero wait; rdata 0.
- Word load at 0x0000_0002 → no read or write strobe; resp_valid with resp_err = 1 one cycle after accept. Size 11 gives the same result.
- Back-to-back store then load with req_valid held → second acceptance in the same cycle as the first resp_valid; read and write never overlap.
- rst_n low while in BUS with waitrequest high → read drops asynchronously, no resp_valid; first request after release completes normally.
